// File: rtl/std_cache_pkg.sv
// Shared std cache types: bypass request/response channel and the bypass arbiter states.
package std_cache_pkg;

  typedef struct packed {
    logic        req;
    logic [3:0]  reqtype;
    logic [3:0]  acetype;
    logic [3:0]  amo;
    logic [3:0]  id;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        we;
    logic [7:0]  be;
    logic [1:0]  size;
  } bypass_req_t;

  typedef struct packed {
    logic        gnt;
    logic        valid;
    logic [63:0] rdata;
  } bypass_rsp_t;

  typedef enum logic [1:0] {BYP_IDLE, BYP_SEND, BYP_WAIT} bypass_arb_state_e;

endpackage

// File: rtl/std_cache_rr_pick.sv
// Combinational round-robin picker: first requester at or above i_rr_ptr, wrapping at NR_PORTS.
module std_cache_rr_pick #(
  parameter int unsigned NR_PORTS = 3
) (
  input  logic [NR_PORTS-1:0]         i_req,
  input  logic [$clog2(NR_PORTS)-1:0] i_rr_ptr,
  output logic                        o_valid,
  output logic [$clog2(NR_PORTS)-1:0] o_idx
);

  localparam int unsigned IDX_W = $clog2(NR_PORTS);
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [IDX_W-1:0]    w_cand [NR_PORTS];
  logic [NR_PORTS-1:0] w_hit;

  // w_cand[gi] is the port examined at search distance gi from the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NR_PORTS; gi++) begin : g_cand
      logic [SUM_W-1:0] w_sum;
      assign w_sum       = {1'b0, i_rr_ptr} + SUM_W'(gi);
      assign w_cand[gi]  = (w_sum >= SUM_W'(NR_PORTS)) ? IDX_W'(w_sum - SUM_W'(NR_PORTS))
                                                       : w_sum[IDX_W-1:0];
      assign w_hit[gi]   = i_req[w_cand[gi]];
    end
  endgenerate

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = NR_PORTS - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_valid = 1'b1;
        o_idx   = w_cand[k];
      end
    end
  end

endmodule

// File: rtl/std_cache_bypass_arbiter.sv
// Round-robin arbiter of uncached bypass requests onto one bypass channel, one transaction in flight.
// Optional per-port stall counters are built when STD_CACHE_BYPASS_ARB_STATS_EN is defined.
module std_cache_bypass_arbiter
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_PORTS = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  bypass_req_t req_i [NR_PORTS],
  output bypass_rsp_t rsp_o [NR_PORTS],
  output bypass_req_t out_req_o,
  input  bypass_rsp_t out_rsp_i,
  output logic        busy_o
`ifdef STD_CACHE_BYPASS_ARB_STATS_EN
  ,
  output logic [31:0] stall_cnt_o [NR_PORTS]
`endif
);

  localparam int unsigned IDX_W = $clog2(NR_PORTS);

  bypass_arb_state_e r_state, w_state_next;
  logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_next;
  logic [IDX_W-1:0]  r_owner, w_owner_next;
  bypass_req_t       r_req_q, w_req_q_next;

  logic [NR_PORTS-1:0] w_req_vec;
  logic                w_pick_valid;
  logic [IDX_W-1:0]    w_pick_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NR_PORTS; gi++) begin : g_req_vec
      assign w_req_vec[gi] = req_i[gi].req;
    end
  endgenerate

  std_cache_rr_pick #(
    .NR_PORTS (NR_PORTS)
  ) u_rr_pick (
    .i_req    (w_req_vec),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= BYP_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_req_q  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_ptr_next;
      r_owner  <= w_owner_next;
      r_req_q  <= w_req_q_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_rr_ptr_next = r_rr_ptr;
    w_owner_next  = r_owner;
    w_req_q_next  = r_req_q;
    out_req_o     = '0;
    for (int k = 0; k < NR_PORTS; k++) begin
      rsp_o[k] = '0;
    end

    unique case (r_state)
      BYP_IDLE: begin
        // Grant is suppressed under reset so nothing is acknowledged that will not be captured.
        if (w_pick_valid && !rst_i) begin
          rsp_o[w_pick_idx].gnt = 1'b1;
          w_req_q_next          = req_i[w_pick_idx];
          w_req_q_next.req      = 1'b1;
          w_owner_next          = w_pick_idx;
          w_rr_ptr_next         = (w_pick_idx == IDX_W'(NR_PORTS - 1)) ? '0
                                                                        : w_pick_idx + IDX_W'(1);
          w_state_next          = BYP_SEND;
        end
      end

      BYP_SEND: begin
        out_req_o     = r_req_q;
        out_req_o.req = 1'b1;
        if (out_rsp_i.gnt) begin
          if (out_rsp_i.valid) begin
            rsp_o[r_owner].valid = 1'b1;
            rsp_o[r_owner].rdata = out_rsp_i.rdata;
            w_state_next         = BYP_IDLE;
          end else begin
            w_state_next = BYP_WAIT;
          end
        end
      end

      BYP_WAIT: begin
        out_req_o     = r_req_q;
        out_req_o.req = 1'b0;
        if (out_rsp_i.valid) begin
          rsp_o[r_owner].valid = 1'b1;
          rsp_o[r_owner].rdata = out_rsp_i.rdata;
          w_state_next         = BYP_IDLE;
        end
      end

      default: begin
        w_state_next = BYP_IDLE;
      end
    endcase
  end

  assign busy_o = (r_state != BYP_IDLE);

`ifdef STD_CACHE_BYPASS_ARB_STATS_EN
  generate
    for (gi = 0; gi < NR_PORTS; gi++) begin : g_stall_cnt
      logic [31:0] r_cnt;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_cnt <= '0;
        end else if (req_i[gi].req && !rsp_o[gi].gnt && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 32'd1;
        end
      end
      assign stall_cnt_o[gi] = r_cnt;
    end
  endgenerate
`endif

`ifndef SYNTHESIS
  // A response is only legal while a transaction is actually waiting for it.
  a_no_stray_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    out_rsp_i.valid |-> ((r_state == BYP_WAIT) || ((r_state == BYP_SEND) && out_rsp_i.gnt)));
`endif

endmodule

// File: tb/tb_std_cache_bypass_arbiter.sv
// Scoreboard bench for std_cache_bypass_arbiter with NR_PORTS = 3.
module tb_std_cache_bypass_arbiter;
  import std_cache_pkg::*;

  localparam int NP = 3;

  logic        clk = 1'b0;
  logic        rst_i;
  bypass_req_t req_i [NP];
  bypass_rsp_t rsp_o [NP];
  bypass_req_t out_req_o;
  bypass_rsp_t out_rsp_i;
  logic        busy_o;
`ifdef STD_CACHE_BYPASS_ARB_STATS_EN
  logic [31:0] stall_cnt_o [NP];
`endif

  typedef struct {
    int          port;
    logic [63:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  std_cache_bypass_arbiter #(
    .NR_PORTS (NP)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .rsp_o     (rsp_o),
    .out_req_o (out_req_o),
    .out_rsp_i (out_rsp_i),
    .busy_o    (busy_o)
`ifdef STD_CACHE_BYPASS_ARB_STATS_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  function automatic logic [2:0] gnt_vec();
    return {rsp_o[2].gnt, rsp_o[1].gnt, rsp_o[0].gnt};
  endfunction

  function automatic logic [2:0] vld_vec();
    return {rsp_o[2].valid, rsp_o[1].valid, rsp_o[0].valid};
  endfunction

  // Response monitor: every routed response is matched against the scoreboard.
  always @(negedge clk) begin
    int   ng;
    int   nv;
    exp_t e;
    ng = 0;
    nv = 0;
    for (int p = 0; p < NP; p++) begin
      if (rsp_o[p].gnt === 1'b1) ng++;
      if (rsp_o[p].valid === 1'b1) nv++;
    end
    n_vec++;
    if (ng > 1) begin
      n_err++;
      $display("FAIL multi_gnt: %0d grants in one cycle, required at most 1", ng);
    end
    n_vec++;
    if (nv > 1) begin
      n_err++;
      $display("FAIL multi_valid: %0d valids in one cycle, required at most 1", nv);
    end
    for (int p = 0; p < NP; p++) begin
      if (rsp_o[p].valid === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rsp: port %0d rdata %h, required no response", p, rsp_o[p].rdata);
        end else begin
          e = exp_q.pop_front();
          if (p !== e.port || rsp_o[p].rdata !== e.rdata) begin
            n_err++;
            $display("FAIL rsp_route: port %0d rdata %h, required port %0d rdata %h",
                     p, rsp_o[p].rdata, e.port, e.rdata);
          end else begin
            $display("txn: response port %0d rdata %h", p, rsp_o[p].rdata);
          end
        end
        for (int q = 0; q < NP; q++) begin
          if (q != p) begin
            n_vec++;
            if (rsp_o[q].rdata !== 64'd0) begin
              n_err++;
              $display("FAIL nonowner_rdata: port %0d rdata %h, required 0", q, rsp_o[q].rdata);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    settle();
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b, required 0", busy_o);
    end
    n_vec++;
    if (out_req_o !== '0) begin
      n_err++;
      $display("FAIL reset_out_req: got %h, required 0", out_req_o);
    end
    for (int p = 0; p < NP; p++) begin
      n_vec++;
      if (rsp_o[p] !== '0) begin
        n_err++;
        $display("FAIL reset_rsp%0d: got %h, required 0", p, rsp_o[p]);
      end
    end
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_single_read();
    bypass_req_t r;
    logic [63:0] rd;
    r      = '0;
    r.req  = 1'b1;
    r.addr = 64'h8000_0040;
    r.size = 2'd3;
    r.id   = 4'h1;
    r.be   = 8'hFF;
    rd     = 64'hDEAD_BEEF_0000_0001;
    req_i[1] = r;
    settle();
    n_vec++;
    if (gnt_vec() !== 3'b010) begin
      n_err++;
      $display("FAIL read_gnt: got %b, required 010", gnt_vec());
    end
    step();
    req_i[1] = '0;
    settle();
    n_vec++;
    if (out_req_o.req !== 1'b1 || out_req_o.addr !== 64'h8000_0040 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL read_send: req %b addr %h busy %b, required 1 80000040 1",
               out_req_o.req, out_req_o.addr, busy_o);
    end
    step();
    out_rsp_i.gnt = 1'b1;
    settle();
    n_vec++;
    if (out_req_o.req !== 1'b1) begin
      n_err++;
      $display("FAIL read_hold: req %b, required 1", out_req_o.req);
    end
    step();
    out_rsp_i = '0;
    settle();
    n_vec++;
    if (out_req_o.req !== 1'b0 || busy_o !== 1'b1 || vld_vec() !== 3'b000) begin
      n_err++;
      $display("FAIL read_wait: req %b busy %b valid %b, required 0 1 000",
               out_req_o.req, busy_o, vld_vec());
    end
    step();
    step();
    out_rsp_i.valid = 1'b1;
    out_rsp_i.rdata = rd;
    exp_q.push_back('{1, rd});
    settle();
    n_vec++;
    if (vld_vec() !== 3'b010 || rsp_o[1].rdata !== rd) begin
      n_err++;
      $display("FAIL read_rsp: valid %b rdata %h, required 010 %h", vld_vec(), rsp_o[1].rdata, rd);
    end
    step();
    out_rsp_i = '0;
    settle();
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL read_idle: busy %b, required 0", busy_o);
    end
  endtask

  task automatic test_round_robin();
    int          ptr;
    int          exp_port;
    logic [63:0] rd;
    logic [2:0]  exp_g;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    for (int p = 0; p < NP; p++) begin
      req_i[p]      = '0;
      req_i[p].req  = 1'b1;
      req_i[p].addr = 64'h1000 + 64'(p) * 64'h100;
      req_i[p].id   = 4'(p);
    end
    ptr = 0;
    for (int k = 0; k < 4; k++) begin
      settle();
      exp_port = ptr;
      ptr      = (exp_port + 1) % NP;
      exp_g    = 3'b001 << exp_port;
      n_vec++;
      if (gnt_vec() !== exp_g) begin
        n_err++;
        $display("FAIL rr_gnt%0d: got %b, required %b", k, gnt_vec(), exp_g);
      end
      step();
      rd              = 64'hA000 + 64'(k);
      out_rsp_i.gnt   = 1'b1;
      out_rsp_i.valid = 1'b1;
      out_rsp_i.rdata = rd;
      exp_q.push_back('{exp_port, rd});
      settle();
      n_vec++;
      if (out_req_o.req !== 1'b1 || out_req_o.addr !== 64'h1000 + 64'(exp_port) * 64'h100
          || gnt_vec() !== 3'b000) begin
        n_err++;
        $display("FAIL rr_send%0d: req %b addr %h gnt %b, required port %0d address, no gnt",
                 k, out_req_o.req, out_req_o.addr, gnt_vec(), exp_port);
      end
      step();
      out_rsp_i = '0;
    end
    for (int p = 0; p < NP; p++) req_i[p] = '0;
  endtask

  task automatic test_backpressure();
    bypass_req_t r;
    bypass_req_t r2;
    logic [63:0] rd;
    r      = '0;
    r.req  = 1'b1;
    r.addr = 64'h2000_0080;
    r.id   = 4'h5;
    r.size = 2'd2;
    r.be   = 8'hF0;
    r2      = '0;
    r2.req  = 1'b1;
    r2.addr = 64'h3000_0000;
    rd      = 64'h0BAD_CAFE_1234_5678;
    req_i[0] = r;
    settle();
    n_vec++;
    if (gnt_vec() !== 3'b001) begin
      n_err++;
      $display("FAIL bp_gnt: got %b, required 001", gnt_vec());
    end
    step();
    req_i[0] = '0;
    req_i[2] = r2;
    for (int i = 0; i < 10; i++) begin
      settle();
      n_vec++;
      if (out_req_o !== r || busy_o !== 1'b1 || gnt_vec() !== 3'b000) begin
        n_err++;
        $display("FAIL bp_hold%0d: out %h busy %b gnt %b, required %h 1 000",
                 i, out_req_o, busy_o, gnt_vec(), r);
      end
      step();
    end
    out_rsp_i.gnt   = 1'b1;
    out_rsp_i.valid = 1'b1;
    out_rsp_i.rdata = rd;
    exp_q.push_back('{0, rd});
    settle();
    step();
    out_rsp_i = '0;
    req_i[2]  = '0;
  endtask

  task automatic test_write();
    bypass_req_t w;
    logic [63:0] rd;
    w         = '0;
    w.req     = 1'b1;
    w.we      = 1'b1;
    w.be      = 8'h0F;
    w.wdata   = 64'h1122_3344_5566_7788;
    w.id      = 4'h3;
    w.addr    = 64'h8000_1000;
    w.size    = 2'd3;
    w.reqtype = 4'h2;
    w.acetype = 4'h1;
    w.amo     = 4'h0;
    rd        = 64'h0000_0000_0000_0077;
    req_i[2] = w;
    settle();
    n_vec++;
    if (gnt_vec() !== 3'b100) begin
      n_err++;
      $display("FAIL wr_gnt: got %b, required 100", gnt_vec());
    end
    step();
    req_i[2] = '0;
    settle();
    n_vec++;
    if (out_req_o !== w) begin
      n_err++;
      $display("FAIL wr_fields: got %h, required %h", out_req_o, w);
    end
    step();
    out_rsp_i.gnt = 1'b1;
    settle();
    step();
    out_rsp_i = '0;
    settle();
    step();
    out_rsp_i.valid = 1'b1;
    out_rsp_i.rdata = rd;
    exp_q.push_back('{2, rd});
    settle();
    n_vec++;
    if (vld_vec() !== 3'b100) begin
      n_err++;
      $display("FAIL wr_rsp_port: valid %b, required 100", vld_vec());
    end
    step();
    out_rsp_i = '0;
  endtask

  task automatic test_reset_mid();
    bypass_req_t r;
    r      = '0;
    r.req  = 1'b1;
    r.addr = 64'h4000_0000;
    req_i[1] = r;
    settle();
    n_vec++;
    if (gnt_vec() !== 3'b010) begin
      n_err++;
      $display("FAIL rmid_gnt: got %b, required 010", gnt_vec());
    end
    step();
    req_i[1] = '0;
    step();
    out_rsp_i.gnt = 1'b1;
    step();
    out_rsp_i = '0;
    settle();
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_wait: busy %b, required 1", busy_o);
    end
    step();
    rst_i = 1'b1;
    step();
    out_rsp_i.valid = 1'b1;
    out_rsp_i.rdata = 64'hFFFF_0000_FFFF_0000;
    settle();
    n_vec++;
    if (busy_o !== 1'b0 || out_req_o !== '0 || vld_vec() !== 3'b000) begin
      n_err++;
      $display("FAIL rmid_idle: busy %b out %h valid %b, required 0 0 000",
               busy_o, out_req_o, vld_vec());
    end
    step();
    rst_i     = 1'b0;
    out_rsp_i = '0;
    req_i[0]  = r;
    req_i[1]  = r;
    settle();
    n_vec++;
    if (busy_o !== 1'b0 || gnt_vec() !== 3'b001) begin
      n_err++;
      $display("FAIL rmid_ptr: busy %b gnt %b, required 0 001", busy_o, gnt_vec());
    end
    req_i[0] = '0;
    req_i[1] = '0;
    step();
  endtask

`ifdef STD_CACHE_BYPASS_ARB_STATS_EN
  task automatic test_stats();
    bypass_req_t r;
    logic [63:0] rd;
    r     = '0;
    r.req = 1'b1;
    rd    = 64'h5151;
    rst_i = 1'b1;
    step();
    rst_i    = 1'b0;
    req_i[1] = r;
    settle();
    step();
    req_i[1] = '0;
    req_i[0] = r;
    step();
    step();
    out_rsp_i.gnt = 1'b1;
    step();
    out_rsp_i = '0;
    step();
    step();
    step();
    out_rsp_i.valid = 1'b1;
    out_rsp_i.rdata = rd;
    exp_q.push_back('{1, rd});
    step();
    out_rsp_i = '0;
    settle();
    n_vec++;
    if (gnt_vec() !== 3'b001 || stall_cnt_o[0] !== 32'd7 || stall_cnt_o[1] !== 32'd0) begin
      n_err++;
      $display("FAIL stats: gnt %b cnt0 %0d cnt1 %0d, required 001 7 0",
               gnt_vec(), stall_cnt_o[0], stall_cnt_o[1]);
    end
    req_i[0] = '0;
    step();
  endtask
`endif

  initial begin
    rst_i     = 1'b1;
    out_rsp_i = '0;
    for (int p = 0; p < NP; p++) req_i[p] = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_write();
    test_reset_mid();
`ifdef STD_CACHE_BYPASS_ARB_STATS_EN
    test_stats();
`endif
    step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
